// File: rtl/roi_window_gate.sv
// Gates a square ROI out of the raw pixel stream; all outputs registered, latency 1 cycle.
// No backpressure: en_out follows input pixel timing and serves directly as a downstream clock enable.
module roi_window_gate #(
  parameter int WIDTH    = 8,
  parameter int X_W      = 11,
  parameter int Y_W      = 11,
  parameter int ROI_SIZE = 64,
  parameter int IDX_W    = 6
) (
  input  logic             CLK_in,
  input  logic             RST_in,
  input  logic [WIDTH-1:0] pix_in,
  input  logic             de_in,
  input  logic             vsync_in,
  input  logic [X_W-1:0]   roi_x,
  input  logic [Y_W-1:0]   roi_y,
  output logic [WIDTH-1:0] pix_out,
  output logic             en_out,
  output logic             sof_out,
  output logic             eol_out,
  output logic             eof_out,
  output logic [IDX_W-1:0] col_out,
  output logic [IDX_W-1:0] row_out
);

  localparam logic [1:0] WAIT_FRAME = 2'd0;
  localparam logic [1:0] ACTIVE     = 2'd1;
  localparam logic [1:0] DONE       = 2'd2;

  localparam logic [X_W:0]     X_SPAN   = (X_W+1)'(ROI_SIZE);
  localparam logic [Y_W:0]     Y_SPAN   = (Y_W+1)'(ROI_SIZE);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(ROI_SIZE - 1);

  logic [1:0]       state;
  logic             vsync_d;
  logic             de_d;
  logic [X_W-1:0]   x;
  logic [Y_W-1:0]   y;
  logic [X_W-1:0]   rx;
  logic [Y_W-1:0]   ry;

  logic             vs_rise;
  logic             line_end;
  logic             in_x;
  logic             in_y;
  logic             hit;
  logic [IDX_W-1:0] col;
  logic [IDX_W-1:0] row;
  logic             last_col;
  logic             last_row;

  // Upper bounds are compared one bit wider so an ROI near the counter limit never wraps.
  always_comb begin
    vs_rise  = vsync_in & ~vsync_d;
    line_end = de_d & ~de_in;
    in_x     = (x >= rx) && ({1'b0, x} < ({1'b0, rx} + X_SPAN));
    in_y     = (y >= ry) && ({1'b0, y} < ({1'b0, ry} + Y_SPAN));
    hit      = (state == ACTIVE) && de_in && in_x && in_y;
    col      = IDX_W'(x - rx);
    row      = IDX_W'(y - ry);
    last_col = (col == IDX_LAST);
    last_row = (row == IDX_LAST);
  end

  always_ff @(posedge CLK_in) begin
    if (RST_in) begin
      state   <= WAIT_FRAME;
      vsync_d <= 1'b1;
      de_d    <= 1'b0;
      x       <= '0;
      y       <= '0;
      rx      <= '0;
      ry      <= '0;
    end else begin
      vsync_d <= vsync_in;
      de_d    <= de_in;

      if (vs_rise) begin
        x  <= '0;
        y  <= '0;
        rx <= roi_x;
        ry <= roi_y;
      end else if (line_end) begin
        x <= '0;
        if (y != '1) y <= y + Y_W'(1);
      end else if (de_in) begin
        x <= x + X_W'(1);
      end

      // A new frame sync always restarts the window, even mid-ROI.
      if (vs_rise)
        state <= ACTIVE;
      else if (hit && last_col && last_row)
        state <= DONE;
      else if (state != WAIT_FRAME && state != ACTIVE && state != DONE)
        state <= WAIT_FRAME;
    end
  end

  always_ff @(posedge CLK_in) begin
    if (RST_in) begin
      pix_out <= '0;
      en_out  <= 1'b0;
      sof_out <= 1'b0;
      eol_out <= 1'b0;
      eof_out <= 1'b0;
      col_out <= '0;
      row_out <= '0;
    end else begin
      en_out  <= hit;
      if (hit) pix_out <= pix_in;
      col_out <= col;
      row_out <= row;
      sof_out <= hit && (col == '0) && (row == '0);
      eol_out <= hit && last_col;
      eof_out <= hit && last_col && last_row;
    end
  end

endmodule

// File: tb/tb_roi_window_gate.sv
// Bench for roi_window_gate with ROI_SIZE=4: table of frame scenarios, directed corner sequences,
// and random frames checked against a window model computed from the frame geometry.
module tb_roi_window_gate;

  localparam int N = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] pix_in;
  logic       de_in;
  logic       vsync_in;
  logic [10:0] roi_x;
  logic [10:0] roi_y;
  logic [7:0] pix_out;
  logic       en_out;
  logic       sof_out;
  logic       eol_out;
  logic       eof_out;
  logic [1:0] col_out;
  logic [1:0] row_out;

  always #5 clk = ~clk;

  roi_window_gate #(
    .WIDTH(8), .X_W(11), .Y_W(11), .ROI_SIZE(N), .IDX_W(2)
  ) dut (
    .CLK_in(clk), .RST_in(rst), .pix_in(pix_in), .de_in(de_in), .vsync_in(vsync_in),
    .roi_x(roi_x), .roi_y(roi_y), .pix_out(pix_out), .en_out(en_out), .sof_out(sof_out),
    .eol_out(eol_out), .eof_out(eof_out), .col_out(col_out), .row_out(row_out)
  );

  typedef struct {
    int         cyc;
    logic [7:0] pix;
    logic       sof;
    logic       eol;
    logic       eof;
    logic [1:0] col;
    logic [1:0] row;
  } strobe_t;

  typedef struct {
    int w, h, blank, rx, ry;
    int cnt, first, last, eols, eofs;
  } vec_t;

  strobe_t obs[$];
  strobe_t exp_q[$];
  vec_t    tbl[6];
  int      in_cyc[0:63][0:63];
  int      cyc = 0;
  int      n_tests = 0;
  int      n_fail = 0;
  int      seen, rst_after;
  bit      rst_pend, rst_done;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk)
    if (en_out === 1'b1)
      obs.push_back('{cyc, pix_out, sof_out, eol_out, eof_out, col_out, row_out});

  task automatic check(input string name, input int act, input int req);
    n_tests++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  function automatic int pack(input strobe_t s);
    return int'({s.pix, s.sof, s.eol, s.eof, s.col, s.row});
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
    if (rst_pend) begin
      rst      = 1'b0;
      rst_pend = 1'b0;
      check("reset_clears_outputs",
            int'({pix_out, en_out, sof_out, eol_out, eof_out, col_out, row_out}), 0);
    end
    if (en_out === 1'b1) seen++;
    if (rst_after > 0 && !rst_done && seen == rst_after) begin
      rst      = 1'b1;
      rst_pend = 1'b1;
      rst_done = 1'b1;
    end
  endtask

  // Drives one frame; optionally truncates it at (stop_line, stop_x), moves the ROI pins
  // to (0,0) at chg_line, or pulses reset after rst_n strobes.
  task automatic drive_frame(input int w, h, blank, rx, ry,
                             input int stop_line, stop_x, chg_line, rst_n);
    for (int yy = 0; yy < 64; yy++)
      for (int xx = 0; xx < 64; xx++) in_cyc[yy][xx] = -1;
    obs.delete();
    seen = 0; rst_after = rst_n; rst_pend = 1'b0; rst_done = 1'b0;
    roi_x = 11'(rx); roi_y = 11'(ry);
    de_in = 1'b0; vsync_in = 1'b1;
    step(); step();
    vsync_in = 1'b0;
    repeat (3) step();
    for (int yy = 0; yy < h; yy++) begin
      if (yy == chg_line) begin roi_x = '0; roi_y = '0; end
      for (int xx = 0; xx < w; xx++) begin
        if (yy == stop_line && xx == stop_x) begin
          de_in = 1'b0;
          step(); step();
          return;
        end
        de_in  = 1'b1;
        pix_in = 8'(yy * w + xx);
        in_cyc[yy][xx] = cyc;
        step();
      end
      de_in = 1'b0;
      repeat (blank) step();
    end
    step(); step();
  endtask

  // Window model: every ROI position inside the frame that was actually driven, in raster order.
  task automatic build_expected(input int w, h, rx, ry, limit);
    exp_q.delete();
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++) begin
        int px, py;
        px = rx + c; py = ry + r;
        if (px < w && py < h && in_cyc[py][px] >= 0 && (limit < 0 || exp_q.size() < limit))
          exp_q.push_back('{in_cyc[py][px] + 1, 8'(py * w + px), (r == 0 && c == 0),
                            (c == N-1), (c == N-1 && r == N-1), 2'(c), 2'(r)});
      end
  endtask

  task automatic compare_frame(input string name);
    int n;
    check({name, " count"}, obs.size(), exp_q.size());
    n = (obs.size() < exp_q.size()) ? obs.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      check($sformatf("%s strobe[%0d]", name, i), pack(obs[i]), pack(exp_q[i]));
      check($sformatf("%s cycle[%0d]", name, i), obs[i].cyc, exp_q[i].cyc);
    end
  endtask

  function automatic int count_eol();
    int k = 0;
    foreach (obs[i]) k += int'(obs[i].eol);
    return k;
  endfunction

  function automatic int count_eof();
    int k = 0;
    foreach (obs[i]) k += int'(obs[i].eof);
    return k;
  endfunction

  initial begin
    //          w   h  bl  rx  ry  cnt first last eols eofs
    tbl[0] = '{16, 12, 4,  2,  3, 16,  50, 101, 4, 1};
    tbl[1] = '{16, 12, 4, 14, 10,  4, 174, 191, 0, 0};
    tbl[2] = '{16, 12, 4,  0,  0, 16,   0,  51, 4, 1};
    tbl[3] = '{16, 12, 4, 12,  8, 16, 140, 191, 4, 1};
    tbl[4] = '{16, 12, 4, 16,  0,  0,   0,   0, 0, 0};
    tbl[5] = '{16, 12, 4,  5, 11,  4, 181, 184, 1, 0};

    rst = 1'b1; de_in = 1'b0; vsync_in = 1'b1; pix_in = '0; roi_x = '0; roi_y = '0;
    seen = 0; rst_after = 0; rst_pend = 1'b0; rst_done = 1'b0;
    repeat (3) step();
    check("reset_state", int'({pix_out, en_out, sof_out, eol_out, eof_out, col_out, row_out}), 0);

    // Startup: reset released with vsync high and a frame already streaming.
    obs.delete();
    rst = 1'b0;
    for (int yy = 0; yy < 5; yy++) begin
      for (int xx = 0; xx < 16; xx++) begin
        de_in = 1'b1; pix_in = 8'(yy * 16 + xx); step();
      end
      de_in = 1'b0; repeat (4) step();
    end
    check("startup_no_strobes", obs.size(), 0);
    vsync_in = 1'b0;
    repeat (2) step();
    drive_frame(16, 12, 4, 2, 3, -1, -1, -1, 0);
    build_expected(16, 12, 2, 3, -1);
    compare_frame("startup_frame");

    for (int i = 0; i < 6; i++) begin
      string nm;
      nm = $sformatf("table[%0d]", i);
      drive_frame(tbl[i].w, tbl[i].h, tbl[i].blank, tbl[i].rx, tbl[i].ry, -1, -1, -1, 0);
      build_expected(tbl[i].w, tbl[i].h, tbl[i].rx, tbl[i].ry, -1);
      compare_frame(nm);
      check({nm, " pulses"}, obs.size(), tbl[i].cnt);
      check({nm, " eol pulses"}, count_eol(), tbl[i].eols);
      check({nm, " eof pulses"}, count_eof(), tbl[i].eofs);
      if (tbl[i].cnt > 0 && obs.size() > 0) begin
        check({nm, " first pix"}, int'(obs[0].pix), tbl[i].first);
        check({nm, " first sof"}, int'(obs[0].sof), 1);
        check({nm, " last pix"}, int'(obs[obs.size()-1].pix), tbl[i].last);
      end
    end

    // ROI pins move mid-frame; the shadowed corner must hold until the next frame.
    drive_frame(16, 12, 4, 2, 3, -1, -1, 5, 0);
    build_expected(16, 12, 2, 3, -1);
    compare_frame("latched_frame");
    drive_frame(16, 12, 4, 0, 0, -1, -1, -1, 0);
    check("latched_next pulses", obs.size(), 16);
    if (obs.size() > 0) begin
      check("latched_next first pix", int'(obs[0].pix), 0);
      check("latched_next first sof", int'(obs[0].sof), 1);
    end

    // Reset pulse one cycle after the 5th strobe, then a clean frame.
    drive_frame(16, 12, 4, 2, 3, -1, -1, -1, 5);
    build_expected(16, 12, 2, 3, 5);
    compare_frame("reset_mid_window");
    drive_frame(16, 12, 4, 2, 3, -1, -1, -1, 0);
    build_expected(16, 12, 2, 3, -1);
    compare_frame("after_reset_frame");

    // Early restart in the middle of ROI row 2 (frame line 5, columns 2..3 driven).
    drive_frame(16, 12, 4, 2, 3, 5, 4, -1, 0);
    build_expected(16, 12, 2, 3, -1);
    compare_frame("truncated_frame");
    check("truncated eof pulses", count_eof(), 0);
    drive_frame(16, 12, 4, 2, 3, -1, -1, -1, 0);
    build_expected(16, 12, 2, 3, -1);
    compare_frame("restarted_frame");
    if (obs.size() > 0) begin
      check("restarted first sof", int'(obs[0].sof), 1);
      check("restarted first row", int'(obs[0].row), 0);
    end

    for (int i = 0; i < 8; i++) begin
      int w, h, bl, rx, ry, sl, sx;
      w  = $urandom_range(4, 40);
      h  = $urandom_range(4, 30);
      bl = $urandom_range(1, 6);
      rx = $urandom_range(0, w + 1);
      ry = $urandom_range(0, h + 1);
      sl = -1; sx = -1;
      if ($urandom_range(0, 2) == 0) begin
        sl = $urandom_range(0, h - 1);
        sx = $urandom_range(1, w - 1);
      end
      drive_frame(w, h, bl, rx, ry, sl, sx, -1, 0);
      build_expected(w, h, rx, ry, -1);
      compare_frame($sformatf("random[%0d]", i));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
